writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 146 ++++++++++++++
 tb/tb_writeback_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// ============================================================================
// Module : writeback_unit
// Writeback stage: MEM/WB register plus a one-entry slow-unit result buffer
// sharing the register-file write port, with starvation-driven pipeline stall.
// Optional feature macro: WB_PC_REDIRECT_EN (dest=15 writes drive pc_wr_*).
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_unit #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_wb_en,
  input  logic        mem_mem_read,
  input  logic [3:0]  mem_dest,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_read_data,
  input  logic        freeze,
  input  logic        slow_valid,
  input  logic [3:0]  slow_dest,
  input  logic [31:0] slow_data,
  output logic        slow_ready,
  output logic [3:0]  destWB,
  output logic [31:0] resultWB,
  output logic        writeBackEn,
  output logic        stall_pipe,
`ifdef WB_PC_REDIRECT_EN
  output logic        pc_wr_en,
  output logic [31:0] pc_wr_data,
`endif
  output logic [14:0] busy_mask
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [3:0] PC_DEST = 4'd15;

  logic        wb_valid;
  logic        wb_wb_en;
  logic        wb_mem_read;
  logic        wb_done;
  logic [3:0]  wb_dest;
  logic [31:0] wb_alu;
  logic [31:0] wb_rdata;

  logic        buf_full;
  logic [3:0]  buf_dest;
  logic [31:0] buf_data;
  logic [3:0]  starve_cnt;

  logic        full_eff;
  logic        pipe_cand;
  logic        slow_grant;
  logic        grant;
  logic [3:0]  sel_dest;
  logic [31:0] sel_data;

  // Everything is masked by rst so a buffered entry is never written during reset.
  always_comb begin
    full_eff   = buf_full & ~rst;
    pipe_cand  = wb_valid & wb_wb_en & ~wb_done & ~rst;
    slow_grant = full_eff & ~pipe_cand;
    grant      = pipe_cand | slow_grant;
    sel_dest   = 4'd0;
    sel_data   = 32'd0;
    if (pipe_cand) begin
      sel_dest = wb_dest;
      sel_data = wb_mem_read ? wb_rdata : wb_alu;
    end else if (slow_grant) begin
      sel_dest = buf_dest;
      sel_data = buf_data;
    end
    writeBackEn = grant && (sel_dest != PC_DEST);
    destWB      = writeBackEn ? sel_dest : 4'd0;
    resultWB    = writeBackEn ? sel_data : 32'd0;
    stall_pipe  = full_eff && (starve_cnt >= LIMIT);
    slow_ready  = ~buf_full & ~rst;
    busy_mask   = 15'd0;
    if (full_eff && (buf_dest != PC_DEST)) begin
      busy_mask[buf_dest] = 1'b1;
    end
  end

`ifdef WB_PC_REDIRECT_EN
  always_comb begin
    pc_wr_en   = grant && (sel_dest == PC_DEST);
    pc_wr_data = pc_wr_en ? sel_data : 32'd0;
  end
`else
  // A granted dest=15 write is consumed here: writeBackEn already excludes it.
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_done    <= 1'b0;
      buf_full   <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      // freeze outranks stall_pipe; done frees the port for the buffer
      if (freeze) begin
        wb_done <= 1'b1;
      end else if (stall_pipe) begin
        wb_valid <= 1'b0;
        wb_done  <= 1'b0;
      end else begin
        wb_valid <= mem_valid;
        wb_done  <= 1'b0;
      end

      if (slow_grant) begin
        buf_full   <= 1'b0;
        starve_cnt <= 4'd0;
      end else if (buf_full) begin
        if (starve_cnt != 4'hF) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= 4'd0;
        if (slow_valid && slow_ready) begin
          buf_full <= 1'b1;
        end
      end
    end
  end

  // Payload registers need no reset: their valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && !freeze && !stall_pipe) begin
      wb_wb_en    <= mem_wb_en;
      wb_mem_read <= mem_mem_read;
      wb_dest     <= mem_dest;
      wb_alu      <= mem_alu_result;
      wb_rdata    <= mem_read_data;
    end
    if (slow_valid && slow_ready) begin
      buf_dest <= slow_dest;
      buf_data <= slow_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module : tb_writeback_unit
// Directed scenarios plus randomized traffic against a cycle-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        mem_valid, mem_wb_en, mem_mem_read;
  logic [3:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_read_data;
  logic        freeze;
  logic        slow_valid;
  logic [3:0]  slow_dest;
  logic [31:0] slow_data;
  logic        slow_ready;
  logic [3:0]  destWB;
  logic [31:0] resultWB;
  logic        writeBackEn;
  logic        stall_pipe;
  logic [14:0] busy_mask;
`ifdef WB_PC_REDIRECT_EN
  logic        pc_wr_en;
  logic [31:0] pc_wr_data;
`endif

  int checks = 0;
  int fails  = 0;

  logic [53:0] exp;
  wire  [53:0] port_obs = {writeBackEn, destWB, resultWB, stall_pipe, slow_ready, busy_mask};

  writeback_unit #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_mem_read(mem_mem_read),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .freeze(freeze),
    .slow_valid(slow_valid), .slow_dest(slow_dest), .slow_data(slow_data),
    .slow_ready(slow_ready),
    .destWB(destWB), .resultWB(resultWB), .writeBackEn(writeBackEn),
    .stall_pipe(stall_pipe),
`ifdef WB_PC_REDIRECT_EN
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
`endif
    .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_wb_en = 0; mem_mem_read = 0; mem_dest = 0;
    mem_alu_result = 0; mem_read_data = 0; freeze = 0;
    slow_valid = 0; slow_dest = 0; slow_data = 0;
  endtask

  task automatic drive_mem(input logic [3:0] d, input logic [31:0] alu);
    mem_valid = 1; mem_wb_en = 1; mem_mem_read = 0; mem_dest = d; mem_alu_result = alu;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL reset_hold: got %h expected %h", port_obs, exp); end
    rst = 0;
    #1;
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL reset_release: got %h expected %h", port_obs, exp); end
`ifdef WB_PC_REDIRECT_EN
    checks++;
    if (pc_wr_en !== 1'b0) begin fails++; $display("FAIL reset_pc: got %b expected 0", pc_wr_en); end
`endif
  endtask

  task automatic test_alu_write();
    drive_mem(4'd3, 32'h11);
    cyc();
    idle_inputs();
    #1;
    exp = {1'b1, 4'd3, 32'h11, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL alu_write: got %h expected %h", port_obs, exp); end
    cyc(); #1;
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL alu_write_once: got %h expected %h", port_obs, exp); end
  endtask

  task automatic test_load();
    drive_mem(4'd7, 32'h1234);
    mem_mem_read = 1; mem_read_data = 32'hDEADBEEF;
    cyc();
    idle_inputs();
    #1;
    exp = {1'b1, 4'd7, 32'hDEADBEEF, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL load_write: got %h expected %h", port_obs, exp); end
    cyc();
  endtask

  task automatic test_starvation();
    drive_mem(4'd1, 32'hA0);
    slow_valid = 1; slow_dest = 4'd5; slow_data = 32'h55;
    cyc();
    slow_valid = 0;
    for (int k = 1; k <= LIMIT; k++) begin
      #1;
      exp = {1'b1, 4'd1, 32'hA0, 1'b0, 1'b0, 15'h0020}; checks++;
      if (port_obs !== exp) begin fails++; $display("FAIL starve_wait%0d: got %h expected %h", k, port_obs, exp); end
      cyc();
    end
    #1;
    exp = {1'b1, 4'd1, 32'hA0, 1'b1, 1'b0, 15'h0020}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL starve_stall: got %h expected %h", port_obs, exp); end
    cyc(); #1;
    exp = {1'b1, 4'd5, 32'h55, 1'b1, 1'b0, 15'h0020}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL starve_drain: got %h expected %h", port_obs, exp); end
    cyc(); #1;
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL starve_release: got %h expected %h", port_obs, exp); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_freeze();
    drive_mem(4'd2, 32'h22);
    slow_valid = 1; slow_dest = 4'd6; slow_data = 32'h66;
    cyc();
    idle_inputs();
    freeze = 1;
    #1;
    exp = {1'b1, 4'd2, 32'h22, 1'b0, 1'b0, 15'h0040}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL freeze_first: got %h expected %h", port_obs, exp); end
    cyc(); #1;
    exp = {1'b1, 4'd6, 32'h66, 1'b0, 1'b0, 15'h0040}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL freeze_drain: got %h expected %h", port_obs, exp); end
    cyc(); #1;
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL freeze_third: got %h expected %h", port_obs, exp); end
    freeze = 0;
    cyc(); #1;
    checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL freeze_release: got %h expected %h", port_obs, exp); end
  endtask

  task automatic test_reset_midop();
    drive_mem(4'd1, 32'hA1);
    slow_valid = 1; slow_dest = 4'd9; slow_data = 32'h99;
    cyc();
    slow_valid = 0;
    #1;
    exp = {1'b1, 4'd1, 32'hA1, 1'b0, 1'b0, 15'h0200}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL midop_full: got %h expected %h", port_obs, exp); end
    cyc();
    rst = 1;
    #1;
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL midop_in_reset: got %h expected %h", port_obs, exp); end
    cyc();
    rst = 0;
    idle_inputs();
    #1;
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL midop_after: got %h expected %h", port_obs, exp); end
    cyc(); #1;
    checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL midop_no_r9: got %h expected %h", port_obs, exp); end
  endtask

  task automatic test_pc_redirect();
    drive_mem(4'd15, 32'h100);
    cyc();
    idle_inputs();
    #1;
    exp = {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 15'd0}; checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL pc_dest15_port: got %h expected %h", port_obs, exp); end
`ifdef WB_PC_REDIRECT_EN
    checks++;
    if ({pc_wr_en, pc_wr_data} !== {1'b1, 32'h100}) begin
      fails++; $display("FAIL pc_redirect: got %b/%h expected 1/00000100", pc_wr_en, pc_wr_data);
    end
`endif
    cyc(); #1;
    checks++;
    if (port_obs !== exp) begin fails++; $display("FAIL pc_after: got %h expected %h", port_obs, exp); end
`ifdef WB_PC_REDIRECT_EN
    checks++;
    if (pc_wr_en !== 1'b0) begin fails++; $display("FAIL pc_after_en: got %b expected 0", pc_wr_en); end
`endif
  endtask

  // Reference: one pending pipeline write per cycle, one slow slot, age in full-and-waiting cycles.
  task automatic test_random();
    logic        m_pcand, m_full, e_stall, took, accept;
    logic [3:0]  m_pdest, m_sdest, sd;
    logic [31:0] m_pdata, m_sdata, sdat;
    int          m_age;
    logic        e_we, e_pc, g;
    logic [3:0]  e_dest;
    logic [31:0] e_data, e_pcd;
    logic [14:0] e_busy;
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    m_pcand = 0; m_full = 0; m_age = 0;
    m_pdest = 0; m_sdest = 0; m_pdata = 0; m_sdata = 0;
    for (int n = 0; n < 800; n++) begin
      mem_valid      = ($urandom % 4) != 0;
      mem_wb_en      = ($urandom % 4) != 0;
      mem_mem_read   = 1'($urandom % 2);
      mem_dest       = 4'($urandom % 16);
      mem_alu_result = $urandom;
      mem_read_data  = $urandom;
      freeze         = ($urandom % 5) == 0;
      slow_valid     = ($urandom % 3) == 0;
      slow_dest      = 4'($urandom % 16);
      slow_data      = $urandom;
      #1;
      e_stall = m_full && (m_age >= LIMIT);
      g = 0; sd = 0; sdat = 0;
      if (m_pcand) begin g = 1; sd = m_pdest; sdat = m_pdata; end
      else if (m_full) begin g = 1; sd = m_sdest; sdat = m_sdata; end
      e_we = g && (sd != 4'd15);
      e_pc = g && (sd == 4'd15);
      e_dest = e_we ? sd : 4'd0;
      e_data = e_we ? sdat : 32'd0;
      e_pcd  = e_pc ? sdat : 32'd0;
      e_busy = (m_full && m_sdest != 4'd15) ? (15'd1 << m_sdest) : 15'd0;
      exp = {e_we, e_dest, e_data, e_stall, !m_full, e_busy}; checks++;
      if (port_obs !== exp) begin fails++; $display("FAIL random[%0d]: got %h expected %h", n, port_obs, exp); end
`ifdef WB_PC_REDIRECT_EN
      checks++;
      if ({pc_wr_en, pc_wr_data} !== {e_pc, e_pcd}) begin
        fails++; $display("FAIL random_pc[%0d]: got %b/%h expected %b/%h", n, pc_wr_en, pc_wr_data, e_pc, e_pcd);
      end
`endif
      took   = !m_pcand && m_full;
      accept = slow_valid && !m_full;
      if (took) begin m_full = 0; m_age = 0; end
      else if (m_full && m_age < 15) m_age = m_age + 1;
      if (accept) begin m_full = 1; m_age = 0; m_sdest = slow_dest; m_sdata = slow_data; end
      if (freeze || e_stall) m_pcand = 0;
      else begin
        m_pcand = mem_valid && mem_wb_en;
        m_pdest = mem_dest;
        m_pdata = mem_mem_read ? mem_read_data : mem_alu_result;
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_alu_write();
    test_load();
    test_starvation();
    test_freeze();
    test_reset_midop();
    test_pc_redirect();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
